// File: rtl/data_memory_hs.sv
// Word-organised data RAM behind a valid/ready request channel with a fixed-latency response pulse.
// Handles RV32I byte/half/word loads and stores, an MMIO LED register, and flags bad accesses.
module data_memory_hs #(
  parameter int          DEPTH_WORDS   = 1024,
  parameter int          READ_LATENCY  = 1,
  parameter logic [31:0] MMIO_LED_ADDR = 32'h8000_0000,
  parameter int          NUM_LEDS      = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [2:0]          req_funct3,
  input  logic [31:0]         req_addr,
  input  logic [31:0]         req_wdata,
  output logic                rsp_valid,
  output logic [31:0]         rsp_rdata,
  output logic                rsp_err,
  output logic [NUM_LEDS-1:0] leds_out
);

  localparam int         IDX_W    = $clog2(DEPTH_WORDS);
  localparam logic [2:0] CNT_INIT = (READ_LATENCY > 1) ? 3'(READ_LATENCY - 2) : 3'd0;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t           state, state_nxt;
  logic [2:0]       cnt;
  logic [31:0]      mem [DEPTH_WORDS];
  logic             accept, illegal, misaligned, is_mmio, mmio_err, out_of_range, err;
  logic [1:0]       size;
  logic [IDX_W-1:0] idx;
  logic [31:0]      word, ld_data, st_data;
  logic [3:0]       st_be;
  logic [7:0]       ld_byte;
  logic [15:0]      ld_half;
  logic [31:0]      pend_rdata;
  logic             pend_err;

  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);
  assign accept    = req_valid & req_ready;

  // funct3[1:0] gives the access size; funct3[2] marks the unsigned load forms
  assign size         = req_funct3[1:0];
  assign illegal      = (req_funct3 == 3'b011) | (req_funct3[2:1] == 2'b11) | (req_we & req_funct3[2]);
  assign misaligned   = ((size == 2'b01) & req_addr[0]) | ((size == 2'b10) & (req_addr[1:0] != 2'b00));
  assign is_mmio      = (req_addr == MMIO_LED_ADDR);
  assign mmio_err     = is_mmio & (size != 2'b10);
  assign out_of_range = ~is_mmio & (|req_addr[31:IDX_W+2]);
  assign err          = illegal | misaligned | mmio_err | out_of_range;

  assign idx     = req_addr[IDX_W+1:2];
  assign word    = is_mmio ? 32'(leds_out) : mem[idx];
  assign ld_byte = word[{req_addr[1:0], 3'b000} +: 8];
  assign ld_half = req_addr[1] ? word[31:16] : word[15:0];

  always_comb begin
    ld_data = '0;
    if (!err) begin
      case (req_funct3)
        3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
        3'b100:  ld_data = {24'h0, ld_byte};
        3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
        3'b101:  ld_data = {16'h0, ld_half};
        3'b010:  ld_data = word;
        default: ld_data = '0;
      endcase
    end
  end

  // Store data is replicated across lanes so the byte enables alone pick the target bytes
  always_comb begin
    st_data = req_wdata;
    st_be   = 4'b1111;
    case (size)
      2'b00: begin
        st_data = {4{req_wdata[7:0]}};
        st_be   = 4'b0001 << req_addr[1:0];
      end
      2'b01: begin
        st_data = {2{req_wdata[15:0]}};
        st_be   = req_addr[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        st_data = req_wdata;
        st_be   = 4'b1111;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (accept && req_we && !err && !is_mmio) begin
      for (int i = 0; i < 4; i++) begin
        if (st_be[i]) mem[idx][8*i +: 8] <= st_data[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = (req_we || READ_LATENCY == 1) ? RESP : WAIT;
      WAIT:    if (cnt == 3'd0) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Loads with extra latency park their result in pend_* until the counter expires
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= 3'd0;
      rsp_rdata  <= '0;
      rsp_err    <= 1'b0;
      pend_rdata <= '0;
      pend_err   <= 1'b0;
      leds_out   <= '0;
    end else if (accept) begin
      if (req_we) begin
        rsp_rdata <= '0;
        rsp_err   <= err;
        if (is_mmio && !err) leds_out <= req_wdata[NUM_LEDS-1:0];
      end else if (READ_LATENCY == 1) begin
        rsp_rdata <= ld_data;
        rsp_err   <= err;
      end else begin
        pend_rdata <= ld_data;
        pend_err   <= err;
        cnt        <= CNT_INIT;
      end
    end else if (state == WAIT) begin
      if (cnt == 3'd0) begin
        rsp_rdata <= pend_rdata;
        rsp_err   <= pend_err;
      end else begin
        cnt <= cnt - 3'd1;
      end
    end
  end

endmodule

// File: tb/tb_data_memory_hs.sv
// Directed testbench for data_memory_hs with a 3-cycle read latency.
module tb_data_memory_hs;

  localparam int LAT = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic [3:0]  leds_out;

  int n_checks = 0;
  int n_errors = 0;

  data_memory_hs #(
    .DEPTH_WORDS  (1024),
    .READ_LATENCY (LAT),
    .MMIO_LED_ADDR(32'h8000_0000),
    .NUM_LEDS     (4)
  ) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_funct3(req_funct3),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .leds_out  (leds_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One request; measures negedges from the accept edge to rsp_valid and checks the response.
  task automatic xact(input string tag, input logic we, input logic [2:0] f3,
                      input logic [31:0] a, input logic [31:0] wd,
                      input logic [31:0] exp_rd, input logic exp_err, input int exp_lat);
    int guard;
    int lat;
    int busy_ready;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
    guard = 0;
    while (!req_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    check({tag, "_accept"}, 32'(req_ready), 32'd1);
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    busy_ready = 0;
    while (!rsp_valid && lat < 20) begin
      if (req_ready) busy_ready++;
      @(negedge clk);
      lat++;
    end
    if (req_ready) busy_ready++;
    check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    check({tag, "_busy"}, 32'(busy_ready), 32'd0);
    check({tag, "_rdata"}, rsp_rdata, exp_rd);
    check({tag, "_err"}, 32'(rsp_err), 32'(exp_err));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int saw;
    int nrsp, nacc, idx;
    bit acc;
    logic [31:0] exp_rd [8];

    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b010;
    req_addr = '0; req_wdata = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_ready", 32'(req_ready), 32'd1);
    check("rst_valid", 32'(rsp_valid), 32'd0);
    check("rst_rdata", rsp_rdata, 32'd0);
    check("rst_err",   32'(rsp_err), 32'd0);
    check("rst_leds",  32'(leds_out), 32'd0);

    xact("sw40",   1, 3'b010, 32'h40, 32'hDEAD_BEEF, 32'h0, 0, 1);
    xact("lw40",   0, 3'b010, 32'h40, 32'h0, 32'hDEAD_BEEF, 0, LAT);

    xact("sw80",   1, 3'b010, 32'h80, 32'h1122_3344, 32'h0, 0, 1);
    xact("sb83",   1, 3'b000, 32'h83, 32'h0000_00AA, 32'h0, 0, 1);
    xact("lw80",   0, 3'b010, 32'h80, 32'h0, 32'hAA22_3344, 0, LAT);
    xact("lb83",   0, 3'b000, 32'h83, 32'h0, 32'hFFFF_FFAA, 0, LAT);
    xact("lbu83",  0, 3'b100, 32'h83, 32'h0, 32'h0000_00AA, 0, LAT);
    xact("lh82",   0, 3'b001, 32'h82, 32'h0, 32'hFFFF_AA22, 0, LAT);
    xact("lhu80",  0, 3'b101, 32'h80, 32'h0, 32'h0000_3344, 0, LAT);
    xact("sh80",   1, 3'b001, 32'h80, 32'h1234_BEEF, 32'h0, 0, 1);
    xact("lw80b",  0, 3'b010, 32'h80, 32'h0, 32'hAA22_BEEF, 0, LAT);

    xact("lh81",   0, 3'b001, 32'h81, 32'h0, 32'h0, 1, LAT);
    xact("sw42",   1, 3'b010, 32'h42, 32'h1234_5678, 32'h0, 1, 1);
    xact("lw40b",  0, 3'b010, 32'h40, 32'h0, 32'hDEAD_BEEF, 0, LAT);
    xact("lw1000", 0, 3'b010, 32'h1000, 32'h0, 32'h0, 1, LAT);
    xact("swffc",  1, 3'b010, 32'hFFC, 32'hCAFE_F00D, 32'h0, 0, 1);
    xact("lwffc",  0, 3'b010, 32'hFFC, 32'h0, 32'hCAFE_F00D, 0, LAT);
    xact("ld011",  0, 3'b011, 32'h40, 32'h0, 32'h0, 1, LAT);
    xact("st100",  1, 3'b100, 32'h40, 32'h0, 32'h0, 1, 1);

    xact("swled",  1, 3'b010, 32'h8000_0000, 32'h0000_0005, 32'h0, 0, 1);
    check("leds5", 32'(leds_out), 32'h5);
    xact("sbled",  1, 3'b000, 32'h8000_0000, 32'h0000_000F, 32'h0, 1, 1);
    check("leds_kept", 32'(leds_out), 32'h5);
    xact("lwled",  0, 3'b010, 32'h8000_0000, 32'h0, 32'h5, 0, LAT);

    // Reset while a load waits in WAIT
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h40;
    @(negedge clk);
    req_valid = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b0;
    saw = 0;
    repeat (3) begin
      @(negedge clk);
      if (rsp_valid) saw++;
    end
    check("rst_mid_leds", 32'(leds_out), 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_mid_ready", 32'(req_ready), 32'd1);
    repeat (5) begin
      if (rsp_valid) saw++;
      @(negedge clk);
    end
    check("rst_mid_norsp", 32'(saw), 32'd0);
    xact("lw40c",  0, 3'b010, 32'h40, 32'h0, 32'hDEAD_BEEF, 0, LAT);

    // Streaming with req_valid held high: sw/lw pairs to consecutive words
    for (int i = 0; i < 8; i++) exp_rd[i] = i[0] ? 32'hA500_0000 + 32'(i - 1) : 32'h0;
    nrsp = 0; nacc = 0; idx = 0;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010;
    req_addr = 32'h100; req_wdata = 32'hA500_0000;
    for (int c = 0; c < 200 && nrsp < 8; c++) begin
      if (rsp_valid) begin
        if (nrsp < 8) begin
          check($sformatf("stream_rdata%0d", nrsp), rsp_rdata, exp_rd[nrsp]);
          check($sformatf("stream_err%0d", nrsp), 32'(rsp_err), 32'd0);
        end
        nrsp++;
      end
      acc = req_valid && req_ready;
      @(negedge clk);
      if (acc) begin
        nacc++;
        idx++;
        if (idx < 8) begin
          req_we    = ~idx[0];
          req_addr  = 32'h100 + 32'(4 * (idx / 2));
          req_wdata = 32'hA500_0000 + 32'(idx);
        end else begin
          req_valid = 1'b0;
        end
      end
    end
    check("stream_nacc", 32'(nacc), 32'd8);
    check("stream_nrsp", 32'(nrsp), 32'd8);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
